inst_fetch_queue: RTL and testbench
===================================

# inst_fetch_queue

Parametrised instruction fetch front end replacing the single-entry IF/ID register of the 5-stage pipeline. Drives the instruction SRAM from its own PC, holds up to DEPTH fetched {pc, inst} pairs in a FIFO, and hands them to decode under a valid/ready handshake. Branch/jump redirects from decode flush the queue and any in-flight fetch, so decode stalls no longer throttle fetch.

## Interface
- DEPTH, 4: queue entries; power of two, ≥2; full throughput needs ≥3.
- AW, 32: address/PC width.
- DW, 32: instruction width.
- RESET_PC, 32'hBFC0_0000: first fetch address after reset.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- fetch_en  in  1  allow new SRAM requests; 0 pauses issue, queue still drains.
- redirect  in  1  flush and restart fetch at redirect_pc.
- redirect_pc  in  AW  new fetch address; word-aligned.
- inst_sram_en  out  1  request strobe; one read per asserted cycle.
- inst_sram_addr  out  AW  request address.
- inst_sram_rdata  in  DW  read data, valid exactly 1 cycle after the request.
- out_valid  out  1  head entry valid.
- out_pc  out  AW  PC of head entry.
- out_inst  out  DW  instruction of head entry.
- out_ready  in  1  decode accepts head this cycle.
- count  out  $clog2(DEPTH+1)  occupied entries.

## Operation
- State: fetch_pc, inflight flag plus inflight_pc, FIFO (wr/rd pointers, count).
- Issue: inst_sram_en = !rst & fetch_en & (count + inflight < DEPTH), or redirect (issues regardless of credit, since the flush frees all credit). Address = redirect ? redirect_pc : fetch_pc.
- On issue, fetch_pc <= issued address + 4 (mod 2^AW, wraps silently); inflight <= 1, inflight_pc <= issued address. No issue → inflight <= 0.
- Response: in the cycle after an issue, inflight=1; {inflight_pc, inst_sram_rdata} is pushed unless dropped.
- Pop: out_valid & out_ready advances rd pointer. Pops in the same cycle do not return credit to issue (credit check uses registered count).
- Redirect: count, pointers cleared; response arriving this cycle dropped; pop this cycle ignored; out_valid is 0 in the next cycle.
- Push/pop same cycle: count unchanged; push to a full queue is impossible by construction (credit rule); a bench assertion flags it.
- fetch_en low: no new issue; an outstanding response still completes and is pushed.
- count may exceed DEPTH only in error; out_valid = (count != 0) (bypass case below).

## Timing
- Reset values: out_valid 0, count 0, inst_sram_en 0, out_pc/out_inst 0, fetch_pc RESET_PC, inflight 0.
- First request in the first cycle with rst=0; data pushed end of cycle 1; out_valid in cycle 2 (latency 2 without bypass).
- Redirect in cycle t: request at redirect_pc in cycle t; out_valid with out_pc=redirect_pc in t+2 (t+1 with bypass).
- Steady state, out_ready held 1, DEPTH≥3: one instruction per cycle.
- rst asserted mid-operation: all state returns to reset values next edge; in-flight response discarded.

## Configuration
- IFQ_BYPASS_EN defined: when the queue is empty and a non-dropped response arrives, it appears combinationally on out_* with out_valid=1 in the same cycle. If it is accepted (out_ready=1), it is not written. Steady-state fetch-to-decode latency is 1; count stays 0 while streaming.
- Undefined: all responses are written to the FIFO first; latency 2; out_* driven purely from registers.

## Structure
- Shared package ifq_pkg: RESET_PC default constant, ifq_entry_t struct {pc, inst} parametrised by AW/DW, and credit-width helper.
- One sub-module: ifq_fifo — synchronous FIFO of ifq_entry_t (DEPTH, push, pop, flush, count, head). Issue/credit/redirect logic lives in inst_fetch_queue.

## Test plan
- Reset then stream with out_ready=1, DEPTH=4, sequential SRAM model → out_pc 0xBFC00000, …04, …08 on consecutive cycles from cycle 2 (cycle 1 with IFQ_BYPASS_EN).
- out_ready=0 for 10 cycles → count saturates at 4, inst_sram_en drops once count+inflight=4, and no entry is lost or duplicated after release.
- redirect with redirect_pc=0x0000_1000 while 3 entries are queued and 1 is in flight → next out_valid carries out_pc 0x1000; none of the stale PCs ever appear.
- redirect together with out_ready=1 and an arriving response → the pop is ignored, the response is dropped, and count=0 on the next cycle.
- fetch_en low for 5 cycles mid-stream → the outstanding fetch is still delivered, no requests are issued, and the stream resumes at the correct next PC.
- fetch_pc=0xFFFF_FFFC → the next request is 0x0000_0000 (wrap), with no stall.

Source files
------------

// File: rtl/ifq_pkg.sv
// Shared types and constants for the instruction fetch queue.
package ifq_pkg;

  localparam logic [31:0] IFQ_RESET_PC = 32'hBFC0_0000;
  localparam int          IFQ_AW       = 32;
  localparam int          IFQ_DW       = 32;

  typedef struct packed {
    logic [IFQ_AW-1:0] pc;
    logic [IFQ_DW-1:0] inst;
  } ifq_entry_t;

  // Width of an occupancy counter that must represent 0..depth inclusive.
  function automatic int ifq_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/ifq_fifo.sv
// Synchronous FIFO of {pc, inst} entries with flush; head is the registered oldest entry.
module ifq_fifo
  import ifq_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = ifq_entry_t
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        push,
  input  T                            push_data,
  input  logic                        pop,
  output T                            head,
  output logic [$clog2(DEPTH+1)-1:0]  count
);

  localparam int CW = ifq_cnt_w(DEPTH);
  localparam int PW = $clog2(DEPTH);

  T              mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_pop;

  assign do_pop = pop && (count != '0);
  assign head   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + PW'(1);
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: entries are only observed while count is non-zero.
  always_ff @(posedge clk) begin
    if (push && !rst && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction fetch front end: PC/issue/credit/redirect control around ifq_fifo.
// Optional combinational empty-queue bypass enabled by defining IFQ_BYPASS_EN.
module inst_fetch_queue
  import ifq_pkg::*;
#(
  parameter int            DEPTH    = 4,
  parameter int            AW       = 32,
  parameter int            DW       = 32,
  parameter logic [AW-1:0] RESET_PC = AW'(IFQ_RESET_PC)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        fetch_en,
  input  logic                        redirect,
  input  logic [AW-1:0]               redirect_pc,
  output logic                        inst_sram_en,
  output logic [AW-1:0]               inst_sram_addr,
  input  logic [DW-1:0]               inst_sram_rdata,
  output logic                        out_valid,
  output logic [AW-1:0]               out_pc,
  output logic [DW-1:0]               out_inst,
  input  logic                        out_ready,
  output logic [$clog2(DEPTH+1)-1:0]  count
);

  localparam int CW = ifq_cnt_w(DEPTH);

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [DW-1:0] inst;
  } entry_t;

  logic [AW-1:0] fetch_pc;
  logic          inflight;
  logic [AW-1:0] inflight_pc;
  logic [CW:0]   occupancy;
  logic          credit_ok;
  logic          resp_valid;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_nonempty;
  entry_t        resp_entry;
  entry_t        head;

  // Credit counts the outstanding response too, so a full queue can never be pushed.
  assign occupancy      = {1'b0, count} + (CW+1)'(inflight);
  assign credit_ok      = occupancy < (CW+1)'(DEPTH);
  assign inst_sram_en   = !rst && (redirect || (fetch_en && credit_ok));
  assign inst_sram_addr = redirect ? redirect_pc : fetch_pc;

  assign resp_valid     = inflight && !redirect;
  assign resp_entry     = '{pc: inflight_pc, inst: inst_sram_rdata};
  assign fifo_nonempty  = (count != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (inst_sram_en) begin
      fetch_pc    <= inst_sram_addr + AW'(4);
      inflight    <= 1'b1;
      inflight_pc <= inst_sram_addr;
    end else begin
      inflight    <= 1'b0;
    end
  end

`ifdef IFQ_BYPASS_EN
  logic bypass;

  assign bypass    = resp_valid && !fifo_nonempty;
  assign fifo_push = resp_valid && !(bypass && out_ready);
  assign fifo_pop  = fifo_nonempty && out_ready && !redirect;
  assign out_valid = fifo_nonempty || bypass;
  assign out_pc    = fifo_nonempty ? head.pc   : (bypass ? inflight_pc     : '0);
  assign out_inst  = fifo_nonempty ? head.inst : (bypass ? inst_sram_rdata : '0);
`else
  assign fifo_push = resp_valid;
  assign fifo_pop  = fifo_nonempty && out_ready && !redirect;
  assign out_valid = fifo_nonempty;
  assign out_pc    = fifo_nonempty ? head.pc   : '0;
  assign out_inst  = fifo_nonempty ? head.inst : '0;
`endif

  ifq_fifo #(
    .DEPTH (DEPTH),
    .T     (entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .push      (fifo_push),
    .push_data (resp_entry),
    .pop       (fifo_pop),
    .head      (head),
    .count     (count)
  );

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed scoreboard bench for inst_fetch_queue; expectations follow IFQ_BYPASS_EN when defined.
module tb_inst_fetch_queue;

  localparam logic [31:0] KEY   = 32'h5A5A_0F0F;
  localparam logic [31:0] RST_PC = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_sram_en;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_rdata = '0;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_ready;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;
  int handshakes = 0;
  logic [31:0] sb[$];

  inst_fetch_queue dut (
    .clk             (clk),
    .rst             (rst),
    .fetch_en        (fetch_en),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_rdata (inst_sram_rdata),
    .out_valid       (out_valid),
    .out_pc          (out_pc),
    .out_inst        (out_inst),
    .out_ready       (out_ready),
    .count           (count)
  );

  always #5 clk = ~clk;

  // SRAM model: data is a keyed function of the address, one cycle after the request.
  always @(posedge clk) if (inst_sram_en) inst_sram_rdata <= inst_sram_addr ^ KEY;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic seed(input logic [31:0] pc);
    sb.delete();
    for (int i = 0; i < 8; i++) sb.push_back(pc + 32'(4 * i));
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    logic [31:0] e;
    if (!rst) begin
      chk("count_le_depth", 64'(count <= 3'd4), 64'd1);
      if (out_valid && out_ready && !redirect) begin
        if (sb.size() == 0) chk("sb_empty", 64'd1, 64'd0);
        else begin
          e = sb.pop_front();
          chk("out_pc", 64'(out_pc), 64'(e));
          chk("out_inst", 64'(out_inst), 64'(e ^ KEY));
          handshakes++;
          if (sb.size() < 8) sb.push_back(sb[sb.size()-1] + 32'd4);
        end
      end
    end
  end

  initial begin
    logic found;
    rst = 1'b1; fetch_en = 1'b0; redirect = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    repeat (3) cyc();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_sram_en", 64'(inst_sram_en), 64'd0);
    chk("rst_out_pc", 64'(out_pc), 64'd0);
    chk("rst_out_inst", 64'(out_inst), 64'd0);

    // cycle 0: first request at the reset PC
    cyc(); rst = 1'b0; fetch_en = 1'b1; out_ready = 1'b1; seed(RST_PC); #1;
    chk("c0_sram_en", 64'(inst_sram_en), 64'd1);
    chk("c0_sram_addr", 64'(inst_sram_addr), 64'(RST_PC));
    chk("c0_out_valid", 64'(out_valid), 64'd0);
    cyc(); #1;
`ifdef IFQ_BYPASS_EN
    chk("c1_out_valid", 64'(out_valid), 64'd1);
    chk("c1_out_pc", 64'(out_pc), 64'(RST_PC));
`else
    chk("c1_out_valid", 64'(out_valid), 64'd0);
`endif
    cyc(); #1;
    chk("c2_out_valid", 64'(out_valid), 64'd1);
`ifndef IFQ_BYPASS_EN
    chk("c2_out_pc", 64'(out_pc), 64'(RST_PC));
`endif
    for (int i = 0; i < 5; i++) begin
      cyc(); #1;
      chk("stream_tput", 64'(out_valid), 64'd1);
    end

    // decode stall: queue saturates, issue stops
    out_ready = 1'b0;
    repeat (10) cyc();
    #1;
    chk("stall_count", 64'(count), 64'd4);
    chk("stall_sram_en", 64'(inst_sram_en), 64'd0);
    out_ready = 1'b1;
    repeat (8) cyc();

    // redirect with 3 queued, 1 in flight, pop and response in the same cycle
    out_ready = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (count == 3'd3) begin found = 1'b1; break; end
    end
    chk("reach_q3", 64'(found), 64'd1);
    redirect = 1'b1; redirect_pc = 32'h0000_1000; out_ready = 1'b1; seed(32'h0000_1000); #1;
    chk("redir_sram_en", 64'(inst_sram_en), 64'd1);
    chk("redir_sram_addr", 64'(inst_sram_addr), 64'h1000);
    cyc(); redirect = 1'b0; #1;
    chk("redir_count", 64'(count), 64'd0);
`ifdef IFQ_BYPASS_EN
    chk("redir_t1_valid", 64'(out_valid), 64'd1);
    chk("redir_t1_pc", 64'(out_pc), 64'h1000);
`else
    chk("redir_t1_valid", 64'(out_valid), 64'd0);
`endif
    cyc(); #1;
    chk("redir_t2_valid", 64'(out_valid), 64'd1);
`ifndef IFQ_BYPASS_EN
    chk("redir_t2_pc", 64'(out_pc), 64'h1000);
`endif
    repeat (4) cyc();

    // fetch pause: no issue, outstanding fetch still delivered, resume at next PC
    fetch_en = 1'b0; #1;
    chk("pause_sram_en", 64'(inst_sram_en), 64'd0);
    for (int i = 0; i < 4; i++) begin
      cyc(); #1;
      chk("pause_sram_en", 64'(inst_sram_en), 64'd0);
    end
    cyc(); fetch_en = 1'b1; #1;
    chk("resume_sram_en", 64'(inst_sram_en), 64'd1);
    chk("resume_addr", 64'(inst_sram_addr), 64'(sb[0]));
    repeat (4) cyc();

    // reset mid-operation
    rst = 1'b1;
    cyc(); rst = 1'b0; seed(RST_PC); #1;
    chk("mrst_count", 64'(count), 64'd0);
    chk("mrst_out_valid", 64'(out_valid), 64'd0);
    chk("mrst_sram_addr", 64'(inst_sram_addr), 64'(RST_PC));
    repeat (4) cyc();

    // PC wrap at the top of the address space
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; seed(32'hFFFF_FFFC); #1;
    chk("wrap_first_addr", 64'(inst_sram_addr), 64'hFFFF_FFFC);
    cyc(); redirect = 1'b0; #1;
    chk("wrap_sram_en", 64'(inst_sram_en), 64'd1);
    chk("wrap_sram_addr", 64'(inst_sram_addr), 64'h0);
    repeat (6) cyc();

    chk("handshakes_seen", 64'(handshakes >= 20), 64'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
